// File: rtl/nobl_sram_ctrl.sv
// ---------------------------------------------------------------------------
// nobl_sram_ctrl
// Initiator-side controller for one NoBL pipelined synchronous SRAM
// (512K x 36, CY7C1370-class). Single-word read/write requests arrive over a
// valid/ready handshake. Write data is driven two clocks after the command.
// Read data returns in order, RD_LAT clocks after the accept edge.
//
// Ports
//   clk, reset          system clock (also the SRAM clock), sync active-high reset
//   req_valid/req_ready client handshake; req_ready is the only combinational output
//   req_wr              1 = write, 0 = read
//   req_addr            word address
//   req_wdata, req_be   write data and active-high byte enables (9-bit lanes)
//   rd_valid, rd_data   one-cycle read return
//   sram_addr           address pins
//   sram_we_b           write enable, low = write
//   sram_bw_b           byte write selects, low = written
//   sram_adv_ld_b       always load (bursts unused)
//   sram_ce_b           combined chip enable
//   sram_oe_b           output enable, low = SRAM may drive
//   sram_cen_b          clock enable, always active
//   sram_wr_data        data towards the pad driver
//   sram_tri_en         1 = FPGA drives the data pads
//   sram_rd_data        data from the pad receiver
// ---------------------------------------------------------------------------
module nobl_sram_ctrl #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 36,
    parameter int NUM_BW = 4,
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [NUM_BW-1:0] req_be,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we_b,
    output logic [NUM_BW-1:0] sram_bw_b,
    output logic              sram_adv_ld_b,
    output logic              sram_ce_b,
    output logic              sram_oe_b,
    output logic              sram_cen_b,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic              sram_tri_en,
    input  logic [DATA_W-1:0] sram_rd_data
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic reset_q;
    logic last_rd_q;
    logic accept;
    logic acc_wr;
    logic acc_rd;

    // A write directly behind a read is held off one cycle so the write
    // drive window cannot collide with the SRAM driving the read data.
    assign req_ready = ~reset_q & ~(last_rd_q & req_wr);
    assign accept    = req_valid & req_ready;
    assign acc_wr    = accept & req_wr;
    assign acc_rd    = accept & ~req_wr;

    always_ff @(posedge clk) begin
        reset_q <= reset;
    end

    // ------------------------------------------------------------------
    // Command pins
    // ------------------------------------------------------------------
    logic              ce_b_q,  ce_b_d;
    logic              we_b_q,  we_b_d;
    logic [NUM_BW-1:0] bw_b_q,  bw_b_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    always_comb begin
        ce_b_d = ~accept;
        we_b_d = ~acc_wr;
        bw_b_d = acc_wr ? ~req_be : '1;
        addr_d = accept ? req_addr : addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_b_q    <= 1'b1;
            we_b_q    <= 1'b1;
            bw_b_q    <= '1;
            addr_q    <= '0;
            last_rd_q <= 1'b0;
        end else begin
            ce_b_q    <= ce_b_d;
            we_b_q    <= we_b_d;
            bw_b_q    <= bw_b_d;
            addr_q    <= addr_d;
            last_rd_q <= acc_rd;
        end
    end

    // ------------------------------------------------------------------
    // Write data path: two delay stages, then the pad output register,
    // so data and drive enable are valid from edge k+2 to edge k+3.
    // ------------------------------------------------------------------
    logic [1:0]        wv_q;
    logic [DATA_W-1:0] wd0_q;
    logic [DATA_W-1:0] wd1_q;
    logic              tri_en_q;
    logic              oe_b_q;
    logic [DATA_W-1:0] wr_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wv_q      <= '0;
            wd0_q     <= '0;
            wd1_q     <= '0;
            tri_en_q  <= 1'b0;
            oe_b_q    <= 1'b1;
            wr_data_q <= '0;
        end else begin
            wv_q     <= {wv_q[0], acc_wr};
            if (acc_wr) begin
                wd0_q <= req_wdata;
            end
            wd1_q    <= wd0_q;
            tri_en_q <= wv_q[1];
            // Output enable is the complement of our own drive enable.
            oe_b_q   <= wv_q[1];
            if (wv_q[1]) begin
                wr_data_q <= wd1_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: tag travels RD_LAT-1 stages, the pad data is captured
    // on the following edge together with rd_valid.
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] rv_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rv_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rv_q       <= {rv_q[RD_LAT-2:0], acc_rd};
            rd_valid_q <= rv_q[RD_LAT-1];
            if (rv_q[RD_LAT-1]) begin
                rd_data_q <= sram_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sram_addr     = addr_q;
    assign sram_we_b     = we_b_q;
    assign sram_bw_b     = bw_b_q;
    assign sram_ce_b     = ce_b_q;
    assign sram_oe_b     = oe_b_q;
    assign sram_wr_data  = wr_data_q;
    assign sram_tri_en   = tri_en_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    // Load every cycle and never gate the SRAM clock.
    assign sram_adv_ld_b = 1'b0;
    assign sram_cen_b    = 1'b0;

endmodule

// File: tb/tb_nobl_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nobl_sram_ctrl
// Directed plus randomized bench for nobl_sram_ctrl. A transaction-level
// reference (shadow memory + expected read queue) predicts client-side
// behaviour; a cycle-level NoBL SRAM model answers the pins.
// ---------------------------------------------------------------------------
module tb_nobl_sram_ctrl;

    localparam int AW = 19;
    localparam int DW = 36;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NB-1:0] req_be = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_addr;
    logic          sram_we_b;
    logic [NB-1:0] sram_bw_b;
    logic          sram_adv_ld_b;
    logic          sram_ce_b;
    logic          sram_oe_b;
    logic          sram_cen_b;
    logic [DW-1:0] sram_wr_data;
    logic          sram_tri_en;
    logic [DW-1:0] sram_rd_data = '0;

    always #5 clk = ~clk;

    nobl_sram_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .NUM_BW(NB),
        .RD_LAT(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .sram_addr    (sram_addr),
        .sram_we_b    (sram_we_b),
        .sram_bw_b    (sram_bw_b),
        .sram_adv_ld_b(sram_adv_ld_b),
        .sram_ce_b    (sram_ce_b),
        .sram_oe_b    (sram_oe_b),
        .sram_cen_b   (sram_cen_b),
        .sram_wr_data (sram_wr_data),
        .sram_tri_en  (sram_tri_en),
        .sram_rd_data (sram_rd_data)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] d,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++)
            if (be[i]) r[9*i +: 9] = d[9*i +: 9];
        return r;
    endfunction

    // ---------------- NoBL SRAM model (pin level) ----------------
    typedef struct {
        bit            v;
        bit            wr;
        logic [AW-1:0] a;
        logic [NB-1:0] bw;
    } cmd_t;

    logic [DW-1:0] smem [logic [AW-1:0]];
    cmd_t          h [3];

    function automatic logic [DW-1:0] smem_get(input logic [AW-1:0] a);
        return smem.exists(a) ? smem[a] : '0;
    endfunction

    initial for (int i = 0; i < 3; i++) h[i] = '{0, 0, '0, '0};

    // Pins seen at a negedge are what the SRAM samples on the next posedge.
    // h[0]/h[1]/h[2] are the commands sampled on the last three posedges.
    always @(negedge clk) begin
        if (h[2].v && !h[2].wr) begin
            sram_rd_data = smem_get(h[2].a);
            chk("turnaround", 64'(sram_tri_en), 64'(0));
        end else begin
            sram_rd_data = DW'({$urandom(), $urandom()});
        end
        if (h[1].v && h[1].wr)
            smem[h[1].a] = merge(smem_get(h[1].a), sram_wr_data, ~h[1].bw);
        h[2] = h[1];
        h[1] = h[0];
        h[0] = '{(sram_ce_b === 1'b0), (sram_we_b === 1'b0), sram_addr, sram_bw_b};
    end

    // ---------------- transaction-level reference ----------------
    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } rd_t;

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    rd_t           rdq [$];
    int unsigned   cyc = 0;
    logic          tb_rst_q = 1'b1;
    bit            sb_en = 0;
    bit            prev_rd = 0;
    bit            whist [3] = '{0, 0, 0};
    logic [DW-1:0] dhist [3] = '{'0, '0, '0};
    logic          exp_ce_b = 1'b1;
    logic          exp_we_b = 1'b1;
    logic [NB-1:0] exp_bw_b = '1;
    logic [AW-1:0] exp_addr = '0;

    function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        tb_rst_q <= reset;
    end

    always @(negedge clk) begin
        bit rdy_exp;
        bit acc;
        if (sb_en) begin
            rdy_exp = !tb_rst_q && !(prev_rd && req_wr);
            chk("req_ready", 64'(req_ready), 64'(rdy_exp));
            chk("ce_b", 64'(sram_ce_b), 64'(exp_ce_b));
            chk("we_b", 64'(sram_we_b), 64'(exp_we_b));
            chk("bw_b", 64'(sram_bw_b), 64'(exp_bw_b));
            chk("addr", 64'(sram_addr), 64'(exp_addr));
            chk("adv_ld_b", 64'(sram_adv_ld_b), 64'(0));
            chk("cen_b", 64'(sram_cen_b), 64'(0));
            chk("tri_en", 64'(sram_tri_en), 64'(whist[2]));
            chk("oe_b", 64'(sram_oe_b), 64'(tb_rst_q | whist[2]));
            if (whist[2]) chk("wr_data", 64'(sram_wr_data), 64'(dhist[2]));
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                chk("rd_valid", 64'(rd_valid), 64'(1));
                chk("rd_data", 64'(rd_data), 64'(rdq[0].data));
                void'(rdq.pop_front());
            end else begin
                chk("rd_valid_idle", 64'(rd_valid), 64'(0));
            end

            acc = req_valid && rdy_exp && !reset;
            if (acc && req_wr)
                ref_mem[req_addr] = merge(ref_get(req_addr), req_wdata, req_be);
            else if (acc)
                rdq.push_back('{ref_get(req_addr), cyc + 5});

            if (reset) begin
                exp_ce_b = 1'b1; exp_we_b = 1'b1; exp_bw_b = '1; exp_addr = '0;
            end else if (acc) begin
                exp_ce_b = 1'b0; exp_we_b = !req_wr;
                exp_bw_b = req_wr ? ~req_be : '1; exp_addr = req_addr;
            end else begin
                exp_ce_b = 1'b1; exp_we_b = 1'b1; exp_bw_b = '1;
            end

            whist[2] = whist[1]; whist[1] = whist[0]; whist[0] = acc && req_wr;
            dhist[2] = dhist[1]; dhist[1] = dhist[0]; dhist[0] = req_wdata;
            if (reset) begin
                whist = '{0, 0, 0};
                rdq.delete();
            end
            prev_rd = acc && !req_wr;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    // Present a request and wait (bounded) for it to be accepted.
    // Returns at accept edge + 1ns with the accept edge number.
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [NB-1:0] be, output int unsigned acc_cyc,
                         output int stalls);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_be = be;
        stalls  = 0;
        acc_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                step();
                acc_cyc = cyc;
                return;
            end
            stalls++;
            step();
        end
        chk("accept_timeout", 64'(req_ready), 64'(1));
    endtask

    // Call right after issue() of a read with nothing else in flight.
    task automatic expect_read(input string tag, input logic [DW-1:0] exp);
        int lat;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(4));
        if (lat >= 0) chk({tag, "_data"}, 64'(rd_data), 64'(exp));
        step();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int unsigned ac, first_ac, last_ac;
        int          st;
        int          nvalid;
        int unsigned vfirst, vlast;
        logic [DW-1:0] got [$];

        // 1. reset held 3 cycles
        step();
        sb_en = 1;
        step();
        @(negedge clk);
        chk("t1_ce_b_in_reset", 64'(sram_ce_b), 64'(1));
        chk("t1_tri_in_reset", 64'(sram_tri_en), 64'(0));
        chk("t1_rdv_in_reset", 64'(rd_valid), 64'(0));
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_ready_first", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("t1_ready_second", 64'(req_ready), 64'(1));
        step();

        // 2. write then read on the next cycle
        issue(1, 19'h00010, 36'h123456789, 4'hF, first_ac, st);
        issue(0, 19'h00010, '0, 4'h0, ac, st);
        chk("t2_no_stall", 64'(st), 64'(0));
        chk("t2_back_to_back", 64'(ac - first_ac), 64'(1));
        idle();
        expect_read("t2", 36'h123456789);

        // 3. full write then partial write then read
        issue(1, 19'h7FFFF, 36'hFFFFFFFFF, 4'hF, ac, st);
        issue(1, 19'h7FFFF, 36'h000000000, 4'b0101, ac, st);
        issue(0, 19'h7FFFF, '0, 4'h0, ac, st);
        idle();
        expect_read("t3", 36'hFF803FE00);

        // 4. read then write: one bubble
        issue(0, 19'h00001, '0, 4'h0, first_ac, st);
        issue(1, 19'h00002, 36'h0CAFE0001, 4'hF, ac, st);
        chk("t4_stall_cycles", 64'(st), 64'(1));
        chk("t4_accept_gap", 64'(ac - first_ac), 64'(2));
        idle();
        repeat (6) step();

        // 5. streaming: fill 0..15, then 16 back-to-back reads
        for (int i = 0; i < 16; i++)
            issue(1, AW'(i), DW'(i * 36'h10101) ^ 36'hA5A5A5A5A, 4'hF, ac, st);
        nvalid = 0; vfirst = 0; vlast = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    issue(0, AW'(i), '0, 4'h0, ac, st);
                    if (i == 0) first_ac = ac;
                    if (i == 15) last_ac = ac;
                end
                idle();
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    @(negedge clk);
                    if (rd_valid === 1'b1) begin
                        if (nvalid == 0) vfirst = cyc;
                        vlast = cyc;
                        nvalid++;
                        got.push_back(rd_data);
                    end
                end
            end
        join
        chk("t5_accept_span", 64'(last_ac - first_ac), 64'(15));
        chk("t5_valid_count", 64'(nvalid), 64'(16));
        chk("t5_valid_span", 64'(vlast - vfirst), 64'(15));
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk("t5_order", 64'(got[i]), 64'(DW'(i * 36'h10101) ^ 36'hA5A5A5A5A));
        step();

        // 6. reset with reads in flight
        issue(0, 19'h00020, '0, 4'h0, ac, st);
        issue(0, 19'h00021, '0, 4'h0, ac, st);
        issue(0, 19'h00022, '0, 4'h0, ac, st);
        idle();
        step();
        reset = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) nvalid++;
            if (i == 1) begin
                chk("t6_ce_b_idle", 64'(sram_ce_b), 64'(1));
                chk("t6_tri_off", 64'(sram_tri_en), 64'(0));
            end
            step();
            if (i == 1) reset = 1'b0;
        end
        chk("t6_dropped_reads", 64'(nvalid), 64'(0));
        issue(0, 19'h00010, '0, 4'h0, ac, st);
        idle();
        expect_read("t6", 36'h123456789);

        // Random traffic on a small address window
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                step();
            end else begin
                issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                      DW'({$urandom(), $urandom()}), NB'($urandom_range(0, 15)), ac, st);
            end
        end
        idle();
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL global_timeout: simulation did not finish");
    end

endmodule
